cycle_host: RTL and testbench
=============================

// Module: cycle_host
// PURPOSE
//  Host-side serial master for the cycle_wrap link. Serialises a 32-bit operand plus ld/pa onto
//  D, strobes DE to commit it, waits a fixed core latency, strobes QE, then deserialises the 32-bit
//  result from Q and samples po. Sits in the test/host FPGA, same clk domain as the wrapped core.
// PARAMETERS
//  WORD_W    32  serial word width (link is fixed at 32; parameter for package consistency only)
//  CORE_LAT  4   idle cycles between the DE cycle and the QE cycle (core compute time)
//  Q_LAT     2   edges from the edge sampling QE to the edge sampling R[31] on Q (2 = direct wire)
// PORTS
//  clk        in   1   clock, all logic on posedge
//  rst_n      in   1   asynchronous active-low reset
//  req_valid  in   1   request present
//  req_ready  out  1   accepting request (high only in IDLE)
//  req_data   in   32  operand to shift out
//  req_ld     in   1   value driven on ld with DE
//  req_pa     in   1   value driven on pa with DE
//  req_rd     in   1   1: perform QE/readback after load; 0: load only
//  rsp_valid  out  1   result available, held until rsp_ready
//  rsp_ready  in   1   result consumer ready
//  rsp_data   out  32  captured R
//  rsp_po     out  2   captured po
//  D DE QE ld pa  out  1 each  link outputs to cycle_wrap, all registered
//  Q          in   1   serial result from cycle_wrap
//  po         in   2   phase output from cycle_wrap
// BEHAVIOUR
//  Reset: all outputs 0 (req_ready 0 during reset, 1 the first cycle after), state IDLE,
//   counters 0. Reset mid-transfer aborts immediately; no partial rsp; DE/QE never left high.
//  FSM: IDLE -> SHIFT -> LOAD -> (req_rd ? WAIT -> QSTB -> DRAIN -> CAPT -> RESP : IDLE).
//  IDLE: req_ready=1; on req_valid&req_ready latch data/ld/pa/rd, go SHIFT.
//  SHIFT: 32 cycles; D = operand bit 31 first, bit 0 last (wrapper shifts left, LSB-in).
//  LOAD: 1 cycle, DE=1 with ld/pa driven; D=0. Wrapper captures all 32 bits on this edge.
//  WAIT: CORE_LAT cycles (0 allowed: go straight to QSTB). QSTB: 1 cycle, QE=1.
//  DRAIN: Q_LAT-1 cycles; CAPT: 32 cycles shifting Q into rsp_data LSB-in, first bit = R[31].
//   po sampled into rsp_po on the first CAPT edge.
//  RESP: rsp_valid=1, data stable; leave to IDLE on rsp_ready. rsp_valid&rsp_ready same cycle ok.
//  DE, QE each high exactly one cycle per request; never both high; ld/pa hold last DE value.
//  Counter: 5-bit, reset to 0 on each phase entry, phase ends at 31 (wrap not used as state).
//  Latency req accept -> rsp_valid: 1+32+1+CORE_LAT+1+(Q_LAT-1)+32 cycles (=72 at defaults).
//  req_valid in non-IDLE states ignored (req_ready=0); no pipelining of requests.
// STRUCTURE
//  cycle_pkg: WORD_W, state enum host_state_t, struct host_req_t {data,ld,pa,rd}.
//  Sub-module cycle_ser_shift: WORD_W-bit shift register, parallel load / shift-out MSB /
//   shift-in LSB; instantiated twice (TX operand, RX result). FSM+counters in cycle_host.
// TESTING  (bench instantiates cycle_wrap + behavioural cycle model driving R, phase_out)
//  1 req_data=32'hDEADBEEF ld=1 pa=0 rd=0 -> wrapper Din=32'hDEADBEEF, load=1 after DE edge;
//    QE never asserted; req_ready back to 1 after 34 cycles.
//  2 model R=32'h80000001, phase_out=2'b10, rd=1 -> rsp_data=32'h80000001, rsp_po=2'b10, 72 cycles.
//  3 rsp_ready held 0 for 10 cycles -> rsp_valid/data stable, req_ready 0; accept then IDLE.
//  4 rst_n low mid-SHIFT (bit 15) and mid-CAPT -> outputs 0 at once, no rsp; next req 32'h1 ok.
//  5 CORE_LAT=0, Q_LAT=3 (one pad register on Q) -> correct R=32'h5A5A_A5A5 captured.
//  6 back-to-back reqs, rsp_ready tied 1 -> DE/QE one-cycle pulses, never overlapping, counts=N.

Source files
------------

// File: rtl/cycle_pkg.sv
// Shared types and widths for the cycle_wrap host link.
package cycle_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned CNT_W  = 5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_LOAD,
    ST_WAIT,
    ST_QSTB,
    ST_DRAIN,
    ST_CAPT,
    ST_RESP
  } host_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic              ld;
    logic              pa;
    logic              rd;
  } host_req_t;

endpackage

// File: rtl/cycle_ser_shift.sv
// W-bit shift register: parallel load, shift left with a serial LSB input.
module cycle_ser_shift
  import cycle_pkg::*;
#(
  parameter int unsigned W = WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_en,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         shift_in,
  output logic [W-1:0] data_o
);

  logic [W-1:0] sr_q, sr_d;

  // Load has priority over shift.
  always_comb begin
    sr_d = sr_q;
    if (load_en) begin
      sr_d = load_data;
    end else if (shift_en) begin
      sr_d = {sr_q[W-2:0], shift_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign data_o = sr_q;

endmodule

// File: rtl/cycle_host.sv
// Host-side serial master for the cycle_wrap link: shifts an operand out on D,
// strobes DE, waits the core latency, strobes QE and shifts the result back in from Q.
module cycle_host
  import cycle_pkg::*;
#(
  parameter int unsigned CORE_LAT = 4,
  parameter int unsigned Q_LAT    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [WORD_W-1:0] req_data,
  input  logic              req_ld,
  input  logic              req_pa,
  input  logic              req_rd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_data,
  output logic [1:0]        rsp_po,
  output logic              D,
  output logic              DE,
  output logic              QE,
  output logic              ld,
  output logic              pa,
  input  logic              Q,
  input  logic [1:0]        po
);

  localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'((CORE_LAT > 0) ? CORE_LAT - 1 : 0);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'((Q_LAT > 1) ? Q_LAT - 2 : 0);

  host_state_t       state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  host_req_t         req_in;
  logic              pend_ld_q, pend_ld_d, pend_pa_q, pend_pa_d, rd_q, rd_d;
  logic              de_q, de_d, qe_q, qe_d, ld_q, ld_d, pa_q, pa_d;
  logic              req_ready_q, req_ready_d, rsp_valid_q, rsp_valid_d;
  logic [1:0]        rsp_po_q, rsp_po_d;
  logic              accept_c, tx_shift_c, rx_shift_c;
  logic [WORD_W-1:0] tx_word, rx_word;
  logic              unused_tx_bits;

  assign req_in = '{data: req_data, ld: req_ld, pa: req_pa, rd: req_rd};

  // Operand goes straight into the TX register on accept; its MSB is the D flop.
  cycle_ser_shift #(.W(WORD_W)) u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (accept_c),
    .load_data(req_in.data),
    .shift_en (tx_shift_c),
    .shift_in (1'b0),
    .data_o   (tx_word)
  );

  cycle_ser_shift #(.W(WORD_W)) u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_en  (1'b0),
    .load_data('0),
    .shift_en (rx_shift_c),
    .shift_in (Q),
    .data_o   (rx_word)
  );

  assign unused_tx_bits = ^tx_word[WORD_W-2:0];

  // Next state; link strobes and handshakes are derived from the next state so they register with it.
  always_comb begin
    state_d    = state_q;
    pend_ld_d  = pend_ld_q;
    pend_pa_d  = pend_pa_q;
    rd_d       = rd_q;
    ld_d       = ld_q;
    pa_d       = pa_q;
    rsp_po_d   = rsp_po_q;
    accept_c   = 1'b0;
    tx_shift_c = 1'b0;
    rx_shift_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          accept_c  = 1'b1;
          pend_ld_d = req_in.ld;
          pend_pa_d = req_in.pa;
          rd_d      = req_in.rd;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        tx_shift_c = 1'b1;
        if (cnt_q == SHIFT_LAST) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (!rd_q)              state_d = ST_IDLE;
        else if (CORE_LAT == 0) state_d = ST_QSTB;
        else                    state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == WAIT_LAST) state_d = ST_QSTB;
      end
      ST_QSTB: begin
        state_d = (Q_LAT > 1) ? ST_DRAIN : ST_CAPT;
      end
      ST_DRAIN: begin
        if (cnt_q == DRAIN_LAST) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        rx_shift_c = 1'b1;
        if (cnt_q == '0) rsp_po_d = po;
        if (cnt_q == SHIFT_LAST) state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q || state_q == ST_IDLE || state_q == ST_RESP) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    de_d        = (state_d == ST_LOAD);
    qe_d        = (state_d == ST_QSTB);
    req_ready_d = (state_d == ST_IDLE);
    rsp_valid_d = (state_d == ST_RESP);
    if (state_d == ST_LOAD) begin
      ld_d = pend_ld_q;
      pa_d = pend_pa_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      pend_ld_q   <= 1'b0;
      pend_pa_q   <= 1'b0;
      rd_q        <= 1'b0;
      de_q        <= 1'b0;
      qe_q        <= 1'b0;
      ld_q        <= 1'b0;
      pa_q        <= 1'b0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_po_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_ld_q   <= pend_ld_d;
      pend_pa_q   <= pend_pa_d;
      rd_q        <= rd_d;
      de_q        <= de_d;
      qe_q        <= qe_d;
      ld_q        <= ld_d;
      pa_q        <= pa_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_po_q    <= rsp_po_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rx_word;
  assign rsp_po    = rsp_po_q;
  assign D         = tx_word[WORD_W-1];
  assign DE        = de_q;
  assign QE        = qe_q;
  assign ld        = ld_q;
  assign pa        = pa_q;

endmodule

// File: tb/tb_cycle_host.sv
// Bench for cycle_host: two hosts (default latencies, and CORE_LAT=0/Q_LAT=3) each talking to a
// behavioural cycle_wrap, checked every cycle against a timeline model of the link protocol.
module tb_cycle_host;

  localparam int unsigned CL0 = 4, QL0 = 2, CL1 = 0, QL1 = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] req_valid, req_ready, req_ld, req_pa, req_rd, rsp_valid, rsp_ready;
  logic [1:0] d_o, de_o, qe_o, ld_o, pa_o, q_i;
  logic [1:0][31:0] req_data, rsp_data;
  logic [1:0][1:0]  rsp_po;
  logic [1:0]  po_i;
  logic [31:0] core_r;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int de_cnt [2];
  int qe_cnt [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  cycle_host #(.CORE_LAT(CL0), .Q_LAT(QL0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_data(req_data[0]), .req_ld(req_ld[0]), .req_pa(req_pa[0]), .req_rd(req_rd[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_data(rsp_data[0]), .rsp_po(rsp_po[0]),
    .D(d_o[0]), .DE(de_o[0]), .QE(qe_o[0]), .ld(ld_o[0]), .pa(pa_o[0]), .Q(q_i[0]), .po(po_i));

  cycle_host #(.CORE_LAT(CL1), .Q_LAT(QL1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_data(req_data[1]), .req_ld(req_ld[1]), .req_pa(req_pa[1]), .req_rd(req_rd[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_data(rsp_data[1]), .rsp_po(rsp_po[1]),
    .D(d_o[1]), .DE(de_o[1]), .QE(qe_o[1]), .ld(ld_o[1]), .pa(pa_o[1]), .Q(q_i[1]), .po(po_i));

  // Behavioural cycle_wrap: input shifter captured on DE, result loaded on QE, registered Q
  // (host 1 sees one extra pad register on Q).
  logic [1:0][31:0] w_sr, w_din, w_osr;
  logic [1:0] w_ld, w_pa, w_q0, w_q1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_sr <= '0; w_din <= '0; w_osr <= '0; w_ld <= '0; w_pa <= '0; w_q0 <= '0; w_q1 <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        w_sr[k] <= {w_sr[k][30:0], d_o[k]};
        if (de_o[k]) begin
          w_din[k] <= w_sr[k];
          w_ld[k]  <= ld_o[k];
          w_pa[k]  <= pa_o[k];
        end
        w_osr[k] <= qe_o[k] ? core_r : {w_osr[k][30:0], 1'b0};
        w_q0[k]  <= w_osr[k][31];
        w_q1[k]  <= w_q0[k];
      end
    end
  end
  assign q_i = {w_q1[1], w_q0[0]};

  function automatic int cl(input int k);
    return (k == 0) ? int'(CL0) : int'(CL1);
  endfunction

  function automatic int lat(input int k);
    return (k == 0) ? int'(1 + 32 + 1 + CL0 + 1 + (QL0 - 1) + 32)
                    : int'(1 + 32 + 1 + CL1 + 1 + (QL1 - 1) + 32);
  endfunction

  // Timeline model: m_t counts cycles since the accept cycle.
  int m_t [2];
  logic [1:0] m_busy, m_ready, m_valid, m_rd, m_rld, m_rpa, m_ldo, m_pao;
  logic [1:0][31:0] m_data, m_er;
  logic [1:0][1:0]  m_epo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= '0; m_ready <= '0; m_valid <= '0; m_rd <= '0; m_rld <= '0; m_rpa <= '0;
      m_ldo <= '0; m_pao <= '0; m_data <= '0; m_er <= '0; m_epo <= '0;
      for (int k = 0; k < 2; k++) m_t[k] <= 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (!m_busy[k]) begin
          m_ready[k] <= 1'b1;
          if (req_valid[k] && m_ready[k]) begin
            m_busy[k]  <= 1'b1;
            m_ready[k] <= 1'b0;
            m_t[k]     <= 1;
            m_data[k]  <= req_data[k];
            m_rld[k]   <= req_ld[k];
            m_rpa[k]   <= req_pa[k];
            m_rd[k]    <= req_rd[k];
            m_er[k]    <= core_r;
            m_epo[k]   <= po_i;
          end
        end else begin
          m_t[k] <= m_t[k] + 1;
          if (m_t[k] + 1 == 33) begin
            m_ldo[k] <= m_rld[k];
            m_pao[k] <= m_rpa[k];
          end
          if (!m_rd[k] && m_t[k] + 1 == 34) begin
            m_busy[k]  <= 1'b0;
            m_ready[k] <= 1'b1;
          end
          if (m_rd[k] && m_t[k] + 1 == lat(k)) m_valid[k] <= 1'b1;
          if (m_valid[k] && rsp_ready[k]) begin
            m_valid[k] <= 1'b0;
            m_busy[k]  <= 1'b0;
            m_ready[k] <= 1'b1;
          end
        end
      end
    end
  end

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] cycle %0d: got %h expected %h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic tmo(input string nm, input int k);
    tests++;
    fails++;
    $display("FAIL %s[%0d] cycle %0d: timed out", nm, k, cyc);
  endtask

  // Per-cycle comparison of every host output against the model.
  always @(negedge clk) begin : cmp
    int t;
    logic exp_d, exp_de, exp_qe;
    for (int k = 0; k < 2; k++) begin
      t      = m_t[k];
      exp_d  = (m_busy[k] && t >= 1 && t <= 32) ? m_data[k][32-t] : 1'b0;
      exp_de = m_busy[k] && (t == 33);
      exp_qe = m_busy[k] && m_rd[k] && (t == 34 + cl(k));
      chk("req_ready", k, 32'(req_ready[k]), 32'(m_ready[k]));
      chk("rsp_valid", k, 32'(rsp_valid[k]), 32'(m_valid[k]));
      chk("D", k, 32'(d_o[k]), 32'(exp_d));
      chk("DE", k, 32'(de_o[k]), 32'(exp_de));
      chk("QE", k, 32'(qe_o[k]), 32'(exp_qe));
      chk("de_qe_overlap", k, 32'(de_o[k] & qe_o[k]), 32'd0);
      chk("ld", k, 32'(ld_o[k]), 32'(m_ldo[k]));
      chk("pa", k, 32'(pa_o[k]), 32'(m_pao[k]));
      if (m_valid[k]) begin
        chk("rsp_data", k, rsp_data[k], m_er[k]);
        chk("rsp_po", k, 32'(rsp_po[k]), 32'(m_epo[k]));
      end
      if (de_o[k]) de_cnt[k]++;
      if (qe_o[k]) qe_cnt[k]++;
    end
  end

  task automatic send(input int k, input logic [31:0] d, input logic l, input logic p,
                      input logic r, output int acc);
    int n = 0;
    @(negedge clk);
    req_data[k] = d; req_ld[k] = l; req_pa[k] = p; req_rd[k] = r; req_valid[k] = 1'b1;
    while (!req_ready[k] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) tmo("accept", k);
    acc = cyc;
    @(posedge clk);
    #1 req_valid[k] = 1'b0;
  endtask

  task automatic wait_ready(input int k, input int acc, input int exp_lat);
    int n = 0;
    while (!req_ready[k] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) tmo("ready_return", k);
    else chk("ready_latency", k, 32'(cyc - acc), 32'(exp_lat));
  endtask

  task automatic get_rsp(input int k, input int acc, input int exp_lat, input logic [31:0] ed,
                         input logic [1:0] ep, input int hold);
    int n = 0;
    while (!rsp_valid[k] && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (n >= 300) begin
      tmo("rsp_wait", k);
      return;
    end
    chk("rsp_latency", k, 32'(cyc - acc), 32'(exp_lat));
    chk("rsp_data_lit", k, rsp_data[k], ed);
    chk("rsp_po_lit", k, 32'(rsp_po[k]), 32'(ep));
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", k, 32'(rsp_valid[k]), 32'd1);
      chk("hold_data", k, rsp_data[k], ed);
      chk("hold_ready", k, 32'(req_ready[k]), 32'd0);
    end
    rsp_ready[k] = 1'b1;
    @(posedge clk);
    #1 rsp_ready[k] = 1'b0;
    @(negedge clk);
    chk("ready_after_rsp", k, 32'(req_ready[k]), 32'd1);
  endtask

  task automatic chk_zero(input string nm);
    chk(nm, 0, 32'({d_o[0], de_o[0], qe_o[0], ld_o[0], pa_o[0], req_ready[0], rsp_valid[0], rsp_po[0]}), 32'd0);
    chk(nm, 0, rsp_data[0], 32'd0);
  endtask

  initial begin : stim
    int a, d0, q0;
    req_valid = '0; req_ld = '0; req_pa = '0; req_rd = '0; rsp_ready = '0; req_data = '0;
    po_i = '0; core_r = '0;
    de_cnt[0] = 0; de_cnt[1] = 0; qe_cnt[0] = 0; qe_cnt[1] = 0;
    repeat (3) @(negedge clk);
    chk_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk);
    chk("ready_after_reset", 0, 32'(req_ready[0]), 32'd1);

    // Load-only request.
    send(0, 32'hDEADBEEF, 1'b1, 1'b0, 1'b0, a);
    wait_ready(0, a, 34);
    chk("t1_din", 0, w_din[0], 32'hDEADBEEF);
    chk("t1_load", 0, 32'(w_ld[0]), 32'd1);
    chk("t1_qe_count", 0, 32'(qe_cnt[0]), 32'd0);

    // Full readback.
    core_r = 32'h80000001; po_i = 2'b10;
    send(0, 32'h12345678, 1'b0, 1'b1, 1'b1, a);
    get_rsp(0, a, 72, 32'h80000001, 2'b10, 0);

    // Back-pressured response.
    core_r = 32'hCAFE0123; po_i = 2'b01;
    send(0, 32'h0F1E2D3C, 1'b1, 1'b1, 1'b1, a);
    get_rsp(0, a, 72, 32'hCAFE0123, 2'b01, 10);

    // Reset during SHIFT (bit 15 on D) and during CAPT.
    send(0, 32'hA5A5F00F, 1'b0, 1'b0, 1'b1, a);
    while (cyc < a + 17) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("reset_mid_shift");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(0, 32'h33334444, 1'b1, 1'b0, 1'b1, a);
    while (cyc < a + 50) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("reset_mid_capt");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    core_r = 32'h00000001; po_i = 2'b11;
    send(0, 32'h00000001, 1'b1, 1'b1, 1'b1, a);
    get_rsp(0, a, 72, 32'h00000001, 2'b11, 0);
    chk("t4_din", 0, w_din[0], 32'h00000001);

    // Zero core latency with a padded Q path.
    core_r = 32'h5A5AA5A5; po_i = 2'b01;
    send(1, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b1, a);
    get_rsp(1, a, 69, 32'h5A5AA5A5, 2'b01, 0);
    chk("t5_din", 1, w_din[1], 32'h0F0F0F0F);

    // Back-to-back requests with the consumer always ready.
    core_r = 32'h13579BDF; po_i = 2'b10;
    rsp_ready[0] = 1'b1;
    d0 = de_cnt[0]; q0 = qe_cnt[0];
    for (int i = 0; i < 3; i++) send(0, 32'h1000 + 32'(i), i[0], ~i[0], 1'b1, a);
    wait_ready(0, a, 73);
    chk("t6_de_pulses", 0, 32'(de_cnt[0] - d0), 32'd3);
    chk("t6_qe_pulses", 0, 32'(qe_cnt[0] - q0), 32'd3);
    chk("t6_din", 0, w_din[0], 32'h00001002);
    rsp_ready[0] = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
